cellrv32_cpu_wb_arbiter: RTL and testbench
==========================================

# cellrv32_cpu_wb_arbiter

Write-back arbiter and long-latency scoreboard sitting directly upstream of the CPU general-purpose register file's single write port. It merges three result producers into one registered write stream: single-cycle pipeline results, load data from the memory unit, and results from a long-latency coprocessor via valid/ready. A small shared FIFO absorbs results that lose arbitration. A per-register pending bitmap flags operand hazards to issue control until the long-latency result is committed.

## Interface
- XLEN, 32, data path width
- RF_ENTRIES, 32, architectural registers (32 for RV32I, 16 for RV32E); all rd/rs indices used modulo RF_ENTRIES
- FIFO_DEPTH, 2, holding-FIFO entries, power of two, >=2
- clk_i  in  1  global clock, rising edge
- rstn_i  in  1  global reset; asynchronous, active-low
- pipe_we_i  in  1  single-cycle result valid (ALU/CSR/next-PC), never stalled
- pipe_rd_i  in  5  destination of pipe result
- pipe_data_i  in  XLEN  pipe result data
- lsu_valid_i  in  1  load data valid, one-cycle pulse, no back-pressure
- lsu_rd_i  in  5  load destination
- lsu_data_i  in  XLEN  load data
- cp_valid_i  in  1  coprocessor result valid
- cp_ready_o  out  1  coprocessor result accepted (transfer = valid & ready)
- cp_rd_i  in  5  coprocessor destination
- cp_data_i  in  XLEN  coprocessor result
- iss_long_i  in  1  a load or coprocessor op with destination iss_rd_i is issued this cycle
- iss_rd_i  in  5  destination of issued long-latency op
- chk_rs1_i  in  5  operand 1 index to check
- chk_rs2_i  in  5  operand 2 index to check
- hazard_o  out  1  operand not yet committed (combinational)
- rf_we_o  out  1  register file write enable (registered)
- rf_rd_o  out  5  register file write address (registered)
- rf_wdata_o  out  XLEN  register file write data (registered)
- busy_o  out  1  FIFO non-empty or any pending bit set
- ovf_o  out  1  sticky: a load result was dropped

## Operation
- Entry filter: any source with rd=0 writes nothing. A pipe write to rd=0 does not claim the port. An lsu/cp result to rd=0 is consumed: a cp transfer still completes, but the result is neither pushed nor written.
- Port selection per cycle, first match wins:
  1. pipe_we_i with rd!=0
  2. FIFO head (pop)
  3. lsu direct, FIFO empty only
  4. cp transfer direct, FIFO empty and no lsu_valid_i
- The selected source loads rf_we_o/rf_rd_o/rf_wdata_o at the next edge. With no source selected, rf_we_o=0 and rd/wdata hold.
- Push: an lsu result or accepted cp result that is not selected is pushed into the FIFO. With both pushing, lsu is pushed first and cp second. FIFO order is strict.
- cp_ready_o = !lsu_valid_i && (count < FIFO_DEPTH).
- Overflow: lsu_valid_i with count==FIFO_DEPTH and no pop that cycle drops the load and sets ovf_o. Push alongside a pop at full is legal, and count stays the same.
- Scoreboard: pending[iss_rd_i] is set at the edge when iss_long_i=1 and rd!=0.
  - pending[rd] clears at the edge after rf_we_o=1 for an lsu/cp-sourced write to rd (the commit edge).
  - Pipe-sourced writes never clear pending.
  - If set and clear hit the same rd in one cycle, set wins.
- hazard_o = pending[rs1] | pending[rs2] | (rf_we_o && rf_rd_o in {rs1,rs2} && rf_rd_o!=0). rs=0 never hazards.

## Timing
- Reset (async assert, sync deassert): rf_we_o=0, rf_rd_o=0, rf_wdata_o=0, FIFO empty, pending all 0, ovf_o=0, busy_o=0, hazard_o=0. cp_ready_o=1 when lsu_valid_i=0.
- Latency, source to rf_we_o: 1 cycle when selected directly; 1 + cycles waited behind pipe writes and older FIFO entries when buffered.
- Throughput: one RF write per cycle. The pipe can starve the FIFO indefinitely by design.
- Reset mid-operation discards FIFO contents and pending bits with no write issued.
- hazard_o is combinational from chk_*, pending, and the output register. It does not depend on same-cycle source inputs.

## Test plan
- Pipe rd=5 data 0x11 alone -> next cycle rf_we_o=1, rf_rd_o=5, rf_wdata_o=0x11. Pipe rd=0 -> rf_we_o=0.
- Issue long rd=7, then load rd=7 data 0xAA while pipe writes rd=3 -> cycle+1 writes x3. Cycle+2 writes x7=0xAA from FIFO. hazard_o for rs1=7 stays high until the edge after the x7 write, then drops.
- Load rd=4 and cp rd=6 valid in the same cycle, FIFO empty, no pipe -> cp_ready_o=0 and load written direct. cp accepted the next cycle and written one cycle later.
- Pipe writes every cycle while 2 loads arrive (DEPTH=2), then a 3rd load -> FIFO full, ovf_o=1 and sticky, cp_ready_o=0. After pipe stops, the two buffered loads are written in order.
- Set and clear of pending rd=9 in the same cycle -> pending[9] remains 1 and hazard_o stays high.
- Assert rstn_i low with 2 FIFO entries and pending bits set -> all outputs 0 immediately and no writes issued after release.

Source files
------------

// File: rtl/cellrv32_cpu_wb_arbiter.sv
`timescale 1ns/1ps
// cellrv32_cpu_wb_arbiter
// Merges pipe, load and coprocessor results onto the single register-file
// write port. Results that lose arbitration wait in a small in-order FIFO.
// A per-register pending bitmap tracks long-latency destinations until their
// result has been committed, and drives the operand hazard flag.
module cellrv32_cpu_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int RF_ENTRIES = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_data_i,
  input  logic            lsu_valid_i,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic            cp_valid_i,
  output logic            cp_ready_o,
  input  logic [4:0]      cp_rd_i,
  input  logic [XLEN-1:0] cp_data_i,
  input  logic            iss_long_i,
  input  logic [4:0]      iss_rd_i,
  input  logic [4:0]      chk_rs1_i,
  input  logic [4:0]      chk_rs2_i,
  output logic            hazard_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            busy_o,
  output logic            ovf_o
);

  localparam int RW = $clog2(RF_ENTRIES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  // Register indices wrap modulo the architectural register count.
  function automatic logic [4:0] rf_idx(input logic [4:0] rd);
    logic [4:0] r;
    r         = '0;
    r[RW-1:0] = rd[RW-1:0];
    return r;
  endfunction

  logic [4:0] pipe_rd_m, lsu_rd_m, cp_rd_m, iss_rd_m, rs1_m, rs2_m;

  // holding FIFO
  wb_t             mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  // output register and commit tracking
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            rf_long_q, rf_long_d;

  logic [RF_ENTRIES-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;

  logic fifo_empty, fifo_full;
  logic pipe_sel, pop, cp_xfer, lsu_ok, cp_ok;
  logic lsu_direct, cp_direct, lsu_push, lsu_drop, cp_push, push;
  wb_t  push_data;
  logic hz_rs1, hz_rs2;

  assign pipe_rd_m = rf_idx(pipe_rd_i);
  assign lsu_rd_m  = rf_idx(lsu_rd_i);
  assign cp_rd_m   = rf_idx(cp_rd_i);
  assign iss_rd_m  = rf_idx(iss_rd_i);
  assign rs1_m     = rf_idx(chk_rs1_i);
  assign rs2_m     = rf_idx(chk_rs2_i);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

  // A load owns the cycle: the coprocessor only hands over a result when no
  // load arrives and the FIFO has room, so at most one push happens per cycle.
  assign cp_ready_o = !lsu_valid_i && !fifo_full;
  assign cp_xfer    = cp_valid_i && cp_ready_o;

  // Results addressed to x0 are consumed without writing or buffering.
  assign lsu_ok = lsu_valid_i && (lsu_rd_m != '0);
  assign cp_ok  = cp_xfer && (cp_rd_m != '0);

  // Port priority: pipe, FIFO head, load direct, coprocessor direct.
  assign pipe_sel   = pipe_we_i && (pipe_rd_m != '0);
  assign pop        = !pipe_sel && !fifo_empty;
  assign lsu_direct = !pipe_sel && fifo_empty && lsu_ok;
  assign cp_direct  = !pipe_sel && fifo_empty && !lsu_valid_i && cp_ok;

  // A pop frees a slot in the same cycle, so a load arriving at full still fits.
  assign lsu_push = lsu_ok && !lsu_direct && (!fifo_full || pop);
  assign lsu_drop = lsu_ok && !lsu_direct && fifo_full && !pop;
  assign cp_push  = cp_ok && !cp_direct;
  assign push     = lsu_push || cp_push;

  // Select the data that enters the FIFO (load first when both could push).
  always_comb begin
    push_data = '0;
    if (lsu_push) begin
      push_data.rd   = lsu_rd_m;
      push_data.data = lsu_data_i;
    end else if (cp_push) begin
      push_data.rd   = cp_rd_m;
      push_data.data = cp_data_i;
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  // Choose the write-port source; rd/wdata hold when nothing is selected.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    rf_long_d  = 1'b0;
    if (pipe_sel) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = pipe_rd_m;
      rf_wdata_d = pipe_data_i;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = mem_q[rptr_q].rd;
      rf_wdata_d = mem_q[rptr_q].data;
      rf_long_d  = 1'b1;
    end else if (lsu_direct) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = lsu_rd_m;
      rf_wdata_d = lsu_data_i;
      rf_long_d  = 1'b1;
    end else if (cp_direct) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = cp_rd_m;
      rf_wdata_d = cp_data_i;
      rf_long_d  = 1'b1;
    end
  end

  // Pending bitmap: clear on long-latency commit, a same-cycle issue wins.
  always_comb begin
    pend_d = pend_q;
    if (rf_we_q && rf_long_q) begin
      pend_d[rf_rd_q[RW-1:0]] = 1'b0;
    end
    if (iss_long_i && (iss_rd_m != '0)) begin
      pend_d[iss_rd_m[RW-1:0]] = 1'b1;
    end
  end

  // Sticky overflow: a load could neither be written nor buffered.
  always_comb begin
    ovf_d = ovf_q || lsu_drop;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      rf_long_q  <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      rf_long_q  <= rf_long_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  // An operand hazards while its producer is pending or is being written now.
  always_comb begin
    hz_rs1 = (rs1_m != '0) && (pend_q[rs1_m[RW-1:0]] || (rf_we_q && (rf_rd_q == rs1_m)));
    hz_rs2 = (rs2_m != '0) && (pend_q[rs2_m[RW-1:0]] || (rf_we_q && (rf_rd_q == rs2_m)));
  end

  assign hazard_o   = hz_rs1 || hz_rs2;
  assign rf_we_o    = rf_we_q;
  assign rf_rd_o    = rf_rd_q;
  assign rf_wdata_o = rf_wdata_q;
  assign busy_o     = !fifo_empty || (|pend_q);
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_cellrv32_cpu_wb_arbiter.sv
`timescale 1ns/1ps
// Randomized and directed bench for cellrv32_cpu_wb_arbiter with a queue-based
// reference model and a scoreboard monitor on the register-file write port.
module tb_cellrv32_cpu_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int RF    = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic            pipe_we_i;
  logic [4:0]      pipe_rd_i;
  logic [XLEN-1:0] pipe_data_i;
  logic            lsu_valid_i;
  logic [4:0]      lsu_rd_i;
  logic [XLEN-1:0] lsu_data_i;
  logic            cp_valid_i;
  logic            cp_ready_o;
  logic [4:0]      cp_rd_i;
  logic [XLEN-1:0] cp_data_i;
  logic            iss_long_i;
  logic [4:0]      iss_rd_i;
  logic [4:0]      chk_rs1_i;
  logic [4:0]      chk_rs2_i;
  logic            hazard_o;
  logic            rf_we_o;
  logic [4:0]      rf_rd_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic            busy_o;
  logic            ovf_o;

  always #5 clk = ~clk;

  cellrv32_cpu_wb_arbiter #(.XLEN(XLEN), .RF_ENTRIES(RF), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .pipe_we_i(pipe_we_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .cp_valid_i(cp_valid_i), .cp_ready_o(cp_ready_o), .cp_rd_i(cp_rd_i), .cp_data_i(cp_data_i),
    .iss_long_i(iss_long_i), .iss_rd_i(iss_rd_i),
    .chk_rs1_i(chk_rs1_i), .chk_rs2_i(chk_rs2_i), .hazard_o(hazard_o),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  int total = 0;
  int bad   = 0;

  wr_t exp_q[$];   // scoreboard: writes the port must present, in order
  wr_t mfifo[$];   // model of results waiting for the port
  logic [RF-1:0] m_pend;
  logic          m_ovf;
  logic          m_we;
  logic [4:0]    m_rd;
  logic          m_long;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [4:0] idx(input logic [4:0] r);
    return 5'(int'(r) % RF);
  endfunction

  function automatic bit hz(input logic [4:0] rs);
    logic [4:0] r;
    r = idx(rs);
    return (r != 0) && (m_pend[r] || (m_we && m_rd == r));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mfifo.delete();
    m_pend = '0;
    m_ovf  = 1'b0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_long = 1'b0;
  endtask

  task automatic set_idle();
    pipe_we_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    cp_valid_i = 0; cp_rd_i = 0; cp_data_i = 0;
    iss_long_i = 0; iss_rd_i = 0;
  endtask

  // One cycle of stimulus: drive, check combinational outputs against the
  // model, then advance the model and record any expected write.
  task automatic cyc(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic cv, input logic [4:0] crd, input logic [31:0] cd,
                     input logic iss, input logic [4:0] ird,
                     input logic [4:0] r1, input logic [4:0] r2);
    wr_t  w;
    logic wv, lng, xfer, cprdy, l_done, c_done;
    @(negedge clk);
    pipe_we_i = pwe; pipe_rd_i = prd; pipe_data_i = pd;
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ld;
    cp_valid_i = cv; cp_rd_i = crd; cp_data_i = cd;
    iss_long_i = iss; iss_rd_i = ird;
    chk_rs1_i = r1; chk_rs2_i = r2;
    #1;
    cprdy = !lv && (mfifo.size() < DEPTH);
    chk("cp_ready", 64'(cp_ready_o), 64'(cprdy));
    chk("hazard", 64'(hazard_o), 64'(hz(r1) || hz(r2)));
    chk("busy", 64'(busy_o), 64'((mfifo.size() != 0) || (m_pend != '0)));
    chk("ovf", 64'(ovf_o), 64'(m_ovf));

    xfer = cv && cprdy;
    wv = 0; lng = 0; l_done = 0; c_done = 0; w = '0;
    if (pwe && idx(prd) != 0) begin
      wv = 1; w.rd = idx(prd); w.data = pd;
    end else if (mfifo.size() != 0) begin
      wv = 1; lng = 1; w = mfifo.pop_front();
    end else if (lv && idx(lrd) != 0) begin
      wv = 1; lng = 1; l_done = 1; w.rd = idx(lrd); w.data = ld;
    end else if (xfer && idx(crd) != 0) begin
      wv = 1; lng = 1; c_done = 1; w.rd = idx(crd); w.data = cd;
    end
    if (lv && idx(lrd) != 0 && !l_done) begin
      wr_t e;
      e.rd = idx(lrd); e.data = ld;
      if (mfifo.size() < DEPTH) mfifo.push_back(e);
      else m_ovf = 1'b1;
    end
    if (xfer && idx(crd) != 0 && !c_done) begin
      wr_t e;
      e.rd = idx(crd); e.data = cd;
      mfifo.push_back(e);
    end
    if (m_we && m_long) m_pend[m_rd] = 1'b0;
    if (iss && idx(ird) != 0) m_pend[idx(ird)] = 1'b1;
    m_we = wv; m_long = lng;
    if (wv) begin
      m_rd = w.rd;
      exp_q.push_back(w);
    end
  endtask

  task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  function automatic logic [4:0] rnd_rd();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
  endfunction

  // Scoreboard monitor: every cycle the write port must match the queue head.
  always @(posedge clk) begin
    #1;
    if (rstn) begin
      wr_t e;
      chk("rf_we", 64'(rf_we_o), 64'(exp_q.size() != 0));
      if (rf_we_o && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rf_rd", 64'(rf_rd_o), 64'(e.rd));
        chk("rf_wdata", 64'(rf_wdata_o), 64'(e.data));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0;
    set_idle();
    chk_rs1_i = 0; chk_rs2_i = 0;
    model_reset();
    #1;
    chk("rst_we", 64'(rf_we_o), 0);
    chk("rst_rd", 64'(rf_rd_o), 0);
    chk("rst_wdata", 64'(rf_wdata_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_ovf", 64'(ovf_o), 0);
    chk("rst_hazard", 64'(hazard_o), 0);
    chk("rst_cp_ready", 64'(cp_ready_o), 1);
    repeat (2) @(negedge clk);
    rstn = 1;

    // pipe alone, then pipe to x0
    cyc(1, 5, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("t1_we", 64'(rf_we_o), 1);
    chk("t1_rd", 64'(rf_rd_o), 5);
    chk("t1_data", 64'(rf_wdata_o), 32'h11);
    cyc(1, 0, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0, 0);

    // long rd=7, load loses to pipe x3, buffered and committed afterwards
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cyc(1, 3, 32'h33, 1, 7, 32'hAA, 0, 0, 0, 0, 0, 7, 0);
    idle(5, 7, 0);
    chk("t2_hazard_clear", 64'(hazard_o), 0);

    // simultaneous load and coprocessor result
    cyc(0, 0, 0, 1, 4, 32'h44, 1, 6, 32'h66, 0, 0, 4, 6);
    cyc(0, 0, 0, 0, 0, 0, 1, 6, 32'h66, 0, 0, 4, 6);
    idle(3, 4, 6);

    // overflow under continuous pipe writes
    cyc(1, 1, 32'h101, 1, 10, 32'hA0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 2, 32'h102, 1, 11, 32'hA1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h103, 1, 12, 32'hA2, 1, 13, 32'hC0, 0, 0, 0, 0);
    cyc(1, 2, 32'h104, 0, 0, 0, 1, 13, 32'hC0, 0, 0, 0, 0);
    chk("t4_cp_ready_full", 64'(cp_ready_o), 0);
    idle(4, 0, 0);
    chk("t4_ovf_sticky", 64'(ovf_o), 1);

    // set and clear of pending x9 in the same cycle
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    cyc(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    idle(4, 9, 0);
    chk("t5_hazard_held", 64'(hazard_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 32'h999, 0, 0, 9, 0);
    idle(3, 9, 0);

    // randomized traffic in bursts of varying pipe density
    for (int b = 0; b < 60; b++) begin
      int pp, lp, cp, ip;
      pp = $urandom_range(0, 100);
      lp = $urandom_range(0, 60);
      cp = $urandom_range(0, 80);
      ip = $urandom_range(0, 50);
      for (int i = 0; i < 50; i++) begin
        cyc($urandom_range(0, 99) < pp, rnd_rd(), $urandom(),
            $urandom_range(0, 99) < lp, rnd_rd(), $urandom(),
            $urandom_range(0, 99) < cp, rnd_rd(), $urandom(),
            $urandom_range(0, 99) < ip, rnd_rd(),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      end
    end
    idle(4, 0, 0);

    // reset with two buffered loads and pending bits set
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    cyc(1, 1, 32'h201, 0, 0, 0, 0, 0, 0, 1, 13, 0, 0);
    cyc(1, 2, 32'h202, 1, 12, 32'hB2, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 3, 32'h203, 1, 13, 32'hB3, 0, 0, 0, 0, 0, 12, 13);
    @(negedge clk);
    set_idle();
    #2;
    rstn = 0;
    model_reset();
    #1;
    chk("mid_rst_we", 64'(rf_we_o), 0);
    chk("mid_rst_rd", 64'(rf_rd_o), 0);
    chk("mid_rst_wdata", 64'(rf_wdata_o), 0);
    chk("mid_rst_busy", 64'(busy_o), 0);
    chk("mid_rst_hazard", 64'(hazard_o), 0);
    chk("mid_rst_ovf", 64'(ovf_o), 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    idle(6, 12, 13);

    // more random traffic after reset
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 1), rnd_rd(), $urandom(),
          $urandom_range(0, 2) == 0, rnd_rd(), $urandom(),
          $urandom_range(0, 1), rnd_rd(), $urandom(),
          $urandom_range(0, 3) == 0, rnd_rd(),
          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    idle(6, 0, 0);
    @(posedge clk); #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
